// File: rtl/ipif_resp_pkg.sv
// ipif_resp_pkg: shared types and constants for the IPIF master-command responder.
//   state_t        : command FSM states (IDLE, ACK, WAIT, DATA, CMPLT)
//   CNT_W          : width of the wait counter (covers LATENCY 0..15 plus a 0..7 stall)
//   LFSR_SEED/TAPS : random-stall LFSR (x^16+x^14+x^13+x^11+1, Galois, right-shifting)
//   READ_MISS_DATA : data returned for a read that misses the register window
package ipif_resp_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACK   = 3'd1,
      WAIT  = 3'd2,
      DATA  = 3'd3,
      CMPLT = 3'd4
   } state_t;

   localparam int          CNT_W          = 5;
   localparam logic [15:0] LFSR_SEED      = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS      = 16'hB400;
   localparam logic [31:0] READ_MISS_DATA = 32'h0000_0000;

   // One step of the right-shifting Galois LFSR: the bit shifted out
   // decides whether the tap mask is folded back in.
   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/ipif_resp_regfile.sv
// ipif_resp_regfile: NUM_REGS x 32-bit register file behind the IPIF responder.
//   clk, rst  : clock and synchronous active-high reset (clears every register)
//   wr_en     : write strobe; wr_idx/wr_be/wr_data sampled on the same edge
//   wr_be     : per-byte write mask, byte k written iff wr_be[k]
//   rd_idx    : combinational read index -> rd_data
//   regs_out  : flat register contents, register i at [32*i +: 32]
//   wr_pulse  : one-cycle pulse on the written index, aligned with the new value
module ipif_resp_regfile #(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [3:0]            wr_be,
   input  logic [31:0]           wr_data,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [31:0]           rd_data,
   output logic [NUM_REGS*32-1:0] regs_out,
   output logic [NUM_REGS-1:0]   wr_pulse
);

   logic [31:0]         words [NUM_REGS];
   logic [NUM_REGS-1:0] wr_pulse_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [31:0] word_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               word_reg <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
               for (int b = 0; b < 4; b++) begin
                  if (wr_be[b]) word_reg[8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end

         assign words[gi]              = word_reg;
         assign regs_out[32*gi +: 32]  = word_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_pulse_reg <= '0;
      end else begin
         wr_pulse_reg <= '0;
         if (wr_en) wr_pulse_reg[wr_idx] <= 1'b1;
      end
   end

   assign rd_data  = words[rd_idx];
   assign wr_pulse = wr_pulse_reg;

endmodule

// File: rtl/ipif_mst_responder.sv
// ipif_mst_responder: target-side responder for the 32-bit IPIF master command
// interface. Accepts single-beat reads/writes, answers CmdAck -> (LATENCY wait)
// -> data phase -> Cmplt/Error, and backs a byte-maskable register file.
//   axi_clk, rst                 : clock, synchronous active-high reset
//   IP2Bus_MstRd_Req/MstWr_Req   : command requests (read wins if both high)
//   IP2Bus_Mst_Addr/BE           : byte address, write byte enables
//   IP2Bus_Mst_Lock              : accepted, no effect
//   IP2Bus_Mst_Reset             : soft abort back to IDLE, no Cmplt
//   Bus2IP_Mst_CmdAck/Cmplt/Error: registered handshake pulses
//   Bus2IP_MstRd_d/src_rdy_n     : one-cycle read data phase
//   IP2Bus_MstWr_d/dst_rdy_n     : one-cycle write data phase
//   regs_out, wr_pulse           : flat register export and write strobes
// Build option: IPIF_RESP_RAND_STALL_EN adds 0..7 LFSR-drawn wait cycles.
module ipif_mst_responder
   import ipif_resp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          NUM_REGS  = 16,
   parameter int          LATENCY   = 2
) (
   input  logic                   axi_clk,
   input  logic                   rst,
   input  logic                   IP2Bus_MstRd_Req,
   input  logic                   IP2Bus_MstWr_Req,
   input  logic [31:0]            IP2Bus_Mst_Addr,
   input  logic [3:0]             IP2Bus_Mst_BE,
   input  logic                   IP2Bus_Mst_Lock,
   input  logic                   IP2Bus_Mst_Reset,
   output logic                   Bus2IP_Mst_CmdAck,
   output logic                   Bus2IP_Mst_Cmplt,
   output logic                   Bus2IP_Mst_Error,
   output logic                   Bus2IP_Mst_Rearbitrate,
   output logic                   Bus2IP_Mst_Timeout,
   output logic [31:0]            Bus2IP_MstRd_d,
   output logic                   Bus2IP_MstRd_src_rdy_n,
   input  logic [31:0]            IP2Bus_MstWr_d,
   output logic                   Bus2IP_MstWr_dst_rdy_n,
   output logic [NUM_REGS*32-1:0] regs_out,
   output logic [NUM_REGS-1:0]    wr_pulse
);

   localparam int IDX_W = $clog2(NUM_REGS);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, wait_total;
   logic             read_reg, hit_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [3:0]       be_reg;

   logic             ack_reg, ack_next, cmplt_reg, cmplt_next, err_reg, err_next;
   logic             src_rdy_n_reg, src_rdy_n_next, dst_rdy_n_reg, dst_rdy_n_next;
   logic [31:0]      rd_d_reg, rd_d_next, rf_rd_data;
   logic             take_cmd, take_read, enter_data, wr_en;

   // Address decode on the live bus; the result is latched with the command.
   logic [31:0]      off;
   logic             addr_hit;
   logic [IDX_W-1:0] addr_idx;
   logic             unused_bits;

   assign off         = IP2Bus_Mst_Addr - BASE_ADDR;
   assign addr_hit    = (IP2Bus_Mst_Addr[1:0] == 2'b00) && (off[31:2] < 30'(NUM_REGS));
   assign addr_idx    = off[2 +: IDX_W];
   assign unused_bits = ^{IP2Bus_Mst_Lock, off[1:0]};

`ifdef IPIF_RESP_RAND_STALL_EN
   logic [15:0] lfsr_reg;

   always_ff @(posedge axi_clk) begin
      if (rst) lfsr_reg <= LFSR_SEED;
      else     lfsr_reg <= lfsr_step(lfsr_reg);
   end

   // Draw taken in ACK, i.e. on entry to the wait phase.
   assign wait_total = CNT_W'(LATENCY) + CNT_W'(lfsr_reg[2:0]);
`else
   assign wait_total = CNT_W'(LATENCY);
`endif

   // Next-state and next-output logic; outputs are registered from these.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      ack_next       = 1'b0;
      cmplt_next     = 1'b0;
      err_next       = 1'b0;
      rd_d_next      = '0;
      src_rdy_n_next = 1'b1;
      dst_rdy_n_next = 1'b1;
      take_cmd       = 1'b0;
      take_read      = 1'b0;
      enter_data     = 1'b0;

      if (IP2Bus_Mst_Reset) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (IP2Bus_MstRd_Req || IP2Bus_MstWr_Req) begin
                  take_cmd   = 1'b1;
                  take_read  = IP2Bus_MstRd_Req;
                  state_next = ACK;
                  ack_next   = 1'b1;
               end
            end
            ACK: begin
               if (wait_total == '0) begin
                  enter_data = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = wait_total;
               end
            end
            WAIT: begin
               if (cnt_reg == CNT_W'(1)) enter_data = 1'b1;
               else                      cnt_next   = cnt_reg - CNT_W'(1);
            end
            DATA: begin
               state_next = CMPLT;
               cmplt_next = 1'b1;
               err_next   = ~hit_reg;
            end
            CMPLT: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase

         if (enter_data) begin
            state_next = DATA;
            if (read_reg) begin
               src_rdy_n_next = 1'b0;
               rd_d_next      = hit_reg ? rf_rd_data : READ_MISS_DATA;
            end else begin
               dst_rdy_n_next = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge axi_clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_ff @(posedge axi_clk) begin
      if (rst) begin
         cnt_reg       <= '0;
         read_reg      <= 1'b0;
         hit_reg       <= 1'b0;
         idx_reg       <= '0;
         be_reg        <= '0;
         ack_reg       <= 1'b0;
         cmplt_reg     <= 1'b0;
         err_reg       <= 1'b0;
         rd_d_reg      <= '0;
         src_rdy_n_reg <= 1'b1;
         dst_rdy_n_reg <= 1'b1;
      end else begin
         cnt_reg       <= cnt_next;
         ack_reg       <= ack_next;
         cmplt_reg     <= cmplt_next;
         err_reg       <= err_next;
         rd_d_reg      <= rd_d_next;
         src_rdy_n_reg <= src_rdy_n_next;
         dst_rdy_n_reg <= dst_rdy_n_next;
         if (take_cmd) begin
            read_reg <= take_read;
            hit_reg  <= addr_hit;
            idx_reg  <= addr_idx;
            be_reg   <= IP2Bus_Mst_BE;
         end
      end
   end

   // Write data is sampled on the edge that closes the data phase; an abort
   // arriving in that same cycle cancels the write.
   assign wr_en = (state_reg == DATA) && !read_reg && hit_reg && !IP2Bus_Mst_Reset;

   ipif_resp_regfile #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .clk      (axi_clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_idx   (idx_reg),
      .wr_be    (be_reg),
      .wr_data  (IP2Bus_MstWr_d),
      .rd_idx   (idx_reg),
      .rd_data  (rf_rd_data),
      .regs_out (regs_out),
      .wr_pulse (wr_pulse)
   );

   assign Bus2IP_Mst_CmdAck      = ack_reg;
   assign Bus2IP_Mst_Cmplt       = cmplt_reg;
   assign Bus2IP_Mst_Error       = err_reg;
   assign Bus2IP_Mst_Rearbitrate = 1'b0;
   assign Bus2IP_Mst_Timeout     = 1'b0;
   assign Bus2IP_MstRd_d         = rd_d_reg;
   assign Bus2IP_MstRd_src_rdy_n = src_rdy_n_reg;
   assign Bus2IP_MstWr_dst_rdy_n = dst_rdy_n_reg;

endmodule

// File: tb/tb_ipif_mst_responder.sv
// tb_ipif_mst_responder: directed, scoreboard-based bench for ipif_mst_responder.
// Expected completions are queued when a command is driven and popped at Cmplt.
// With IPIF_RESP_RAND_STALL_EN defined the DUT runs at LATENCY=0 and the
// CmdAck-to-data gap is checked against the 1..8 window instead of exactly.
module tb_ipif_mst_responder;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          NUM  = 16;
`ifdef IPIF_RESP_RAND_STALL_EN
   localparam int          LAT  = 0;
`else
   localparam int          LAT  = 2;
`endif

   logic              axi_clk = 1'b0;
   logic              rst;
   logic              rd_req, wr_req, mst_lock, mst_reset;
   logic [31:0]       mst_addr, wr_d;
   logic [3:0]        mst_be;
   logic              cmd_ack, cmplt, err, rearb, tmo, src_rdy_n, dst_rdy_n;
   logic [31:0]       rd_d;
   logic [NUM*32-1:0] regs_out;
   logic [NUM-1:0]    wr_pulse;

   always #5 axi_clk = ~axi_clk;

   ipif_mst_responder #(
      .BASE_ADDR (BASE),
      .NUM_REGS  (NUM),
      .LATENCY   (LAT)
   ) dut (
      .axi_clk                (axi_clk),
      .rst                    (rst),
      .IP2Bus_MstRd_Req       (rd_req),
      .IP2Bus_MstWr_Req       (wr_req),
      .IP2Bus_Mst_Addr        (mst_addr),
      .IP2Bus_Mst_BE          (mst_be),
      .IP2Bus_Mst_Lock        (mst_lock),
      .IP2Bus_Mst_Reset       (mst_reset),
      .Bus2IP_Mst_CmdAck      (cmd_ack),
      .Bus2IP_Mst_Cmplt       (cmplt),
      .Bus2IP_Mst_Error       (err),
      .Bus2IP_Mst_Rearbitrate (rearb),
      .Bus2IP_Mst_Timeout     (tmo),
      .Bus2IP_MstRd_d         (rd_d),
      .Bus2IP_MstRd_src_rdy_n (src_rdy_n),
      .IP2Bus_MstWr_d         (wr_d),
      .Bus2IP_MstWr_dst_rdy_n (dst_rdy_n),
      .regs_out               (regs_out),
      .wr_pulse               (wr_pulse)
   );

   typedef struct {
      bit          rd;
      bit          err;
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] pulse;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [NUM];
   int          n_eval = 0;
   int          n_fail = 0;
   int          first_ack_cyc;
   int          ack_after_cmplt;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      logic [NUM*32-1:0] flat;
      for (int i = 0; i < NUM; i++) flat[32*i +: 32] = model[i];
      check(tag, regs_out, flat);
   endtask

   // Compute the expected completion and update the register model.
   task automatic expect_txn(input bit rd, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata);
      exp_t        e;
      logic [31:0] off;
      bit          h;
      int          idx;
      off     = addr - BASE;
      h       = (addr[1:0] == 2'b00) && ((off >> 2) < 32'(NUM));
      idx     = h ? int'(off >> 2) : 0;
      e.rd    = rd;
      e.err   = !h;
      e.addr  = addr;
      e.data  = 32'h0;
      e.pulse = 16'h0;
      if (rd) begin
         e.data = h ? model[idx] : 32'h0;
      end else if (h) begin
         for (int k = 0; k < 4; k++)
            if (be[k]) model[idx][8*k +: 8] = wdata[8*k +: 8];
         e.pulse = 16'(1) << idx;
      end
      sb.push_back(e);
   endtask

   // Wait one idle cycle, then present a command and queue its expectation.
   task automatic start(input bit rd, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata);
      @(negedge axi_clk);
      mst_addr = addr;
      mst_be   = be;
      wr_d     = wdata;
      if (rd) rd_req = 1'b1;
      else    wr_req = 1'b1;
      expect_txn(rd, addr, be, wdata);
   endtask

   // Monitor until n completions, dropping each request once it is acked.
   task automatic run(input int n, input int budget);
      int  cyc = 0, done = 0, last_cmplt = 0;
      int  ack_cyc = 0, data_cyc = 0, beats = 0;
      bit  saw_rd = 0, saw_wr = 0, first = 1;
      logic [31:0] rdata = '0;
      logic [15:0] pulse_acc = '0;
      exp_t e;
      while (done < n && cyc < budget) begin
         @(negedge axi_clk);
         cyc++;
         if (cmd_ack) begin
            ack_cyc = cyc;
            if (first) begin first_ack_cyc = cyc; first = 0; end
            if (last_cmplt > 0) ack_after_cmplt = cyc - last_cmplt;
            if (rd_req) rd_req = 1'b0;
            else        wr_req = 1'b0;
         end
         if (!src_rdy_n) begin saw_rd = 1; data_cyc = cyc; rdata = rd_d; beats++; end
         if (!dst_rdy_n) begin saw_wr = 1; data_cyc = cyc; beats++; end
         pulse_acc |= wr_pulse;
         if (cmplt) begin
            if (sb.size() == 0) begin
               check("unexpected_cmplt", 1'b1, 1'b0);
            end else begin
               e = sb.pop_front();
               $display("txn %s addr=%08h err=%0b data=%08h at cycle %0d",
                        e.rd ? "RD" : "WR", e.addr, err, e.rd ? rdata : wr_d, cyc);
               check("direction", {saw_rd, saw_wr}, {e.rd, !e.rd});
               check("error", err, e.err);
               if (e.rd) check("rd_data", rdata, e.data);
               check("data_beats", beats, 1);
               check("cmplt_after_data", cyc - data_cyc, 1);
`ifdef IPIF_RESP_RAND_STALL_EN
               check("gap_in_window", (data_cyc - ack_cyc >= LAT + 1) &&
                                      (data_cyc - ack_cyc <= LAT + 8), 1'b1);
`else
               check("ack_to_data", data_cyc - ack_cyc, LAT + 1);
`endif
               check("wr_pulse_at_cmplt", wr_pulse, e.pulse);
               check("wr_pulse_total", pulse_acc, e.pulse);
            end
            done++;
            last_cmplt = cyc;
            saw_rd = 0; saw_wr = 0; beats = 0; pulse_acc = '0;
         end
      end
      if (done < n) check("timeout_cmplt", done, n);
   endtask

   initial begin
      int activity;
      bit got_ack;
      rst = 1'b1; rd_req = 0; wr_req = 0; mst_lock = 0; mst_reset = 0;
      mst_addr = '0; mst_be = '0; wr_d = '0;
      for (int i = 0; i < NUM; i++) model[i] = '0;

      // Reset and idle values.
      repeat (3) @(negedge axi_clk);
      rst = 1'b0;
      activity = 0;
      repeat (3) begin
         @(negedge axi_clk);
         activity += int'(cmd_ack) + int'(cmplt);
      end
      check("idle_no_ack", activity, 0);
      check("rst_err", err, 1'b0);
      check("rst_rd_d", rd_d, 32'h0);
      check("rst_rdy_n", {src_rdy_n, dst_rdy_n}, 2'b11);
      check("rst_tied", {rearb, tmo}, 2'b00);
      check("rst_wr_pulse", wr_pulse, 16'h0);
      check_regs("rst_regs");

      // Full write, then exact first-ack timing.
      start(0, BASE + 32'h8, 4'hF, 32'hCAFEF00D);
      run(1, 60);
      check("first_ack_cycle", first_ack_cyc, 1);
      check_regs("regs_full_write");

      // Partial write then read back.
      start(0, BASE + 32'h8, 4'b0101, 32'h11223344);
      run(1, 60);
      start(1, BASE + 32'h8, 4'h0, 32'h0);
      run(1, 60);
      check("reg2_partial", regs_out[32*2 +: 32], 32'hCA22F044);

      // Decode misses.
      start(1, BASE + 32'h40, 4'hF, 32'h0);
      run(1, 60);
      start(0, BASE + 32'h5, 4'hF, 32'hFFFFFFFF);
      run(1, 60);
      check_regs("regs_after_miss");

      // Read and write raised together: read first, write after.
      @(negedge axi_clk);
      mst_addr = BASE + 32'h8; mst_be = 4'hF; wr_d = 32'hA5A50001;
      rd_req = 1'b1; wr_req = 1'b1;
      expect_txn(1, BASE + 32'h8, 4'hF, 32'h0);
      expect_txn(0, BASE + 32'h8, 4'hF, 32'hA5A50001);
      ack_after_cmplt = 0;
      run(2, 120);
      check("prio_write_ack_gap", ack_after_cmplt, 2);
      check_regs("regs_after_prio");

      // Soft abort during the wait phase; requests ignored while it is high.
      @(negedge axi_clk);
      mst_addr = BASE + 32'h10; mst_be = 4'hF; wr_d = 32'hDEADBEEF; wr_req = 1'b1;
      got_ack = 0;
      for (int c = 0; c < 10 && !got_ack; c++) begin
         @(negedge axi_clk);
         if (cmd_ack) got_ack = 1;
      end
      check("abort_ack_seen", got_ack, 1'b1);
      wr_req = 1'b0;
      @(negedge axi_clk);
      mst_reset = 1'b1; rd_req = 1'b1;
      activity = 0;
      repeat (2) begin
         @(negedge axi_clk);
         activity += int'(cmd_ack) + int'(cmplt) + int'(!src_rdy_n) + int'(!dst_rdy_n);
      end
      mst_reset = 1'b0; rd_req = 1'b0;
      repeat (8) begin
         @(negedge axi_clk);
         activity += int'(cmd_ack) + int'(cmplt) + int'(!src_rdy_n) + int'(!dst_rdy_n);
      end
      check("abort_quiet", activity, 0);
      check_regs("regs_after_abort");
      start(1, BASE + 32'h10, 4'h0, 32'h0);
      run(1, 60);
      check("post_abort_ack_cycle", first_ack_cyc, 1);

      // Fill every register with random bytes, then 100 reads incl. misses.
      for (int i = 0; i < NUM; i++) begin
         start(0, BASE + 32'(4 * i), 4'($urandom_range(1, 15)), $urandom);
         run(1, 60);
      end
      check_regs("regs_after_fill");
      for (int i = 0; i < 100; i++) begin
         start(1, BASE + 32'(4 * $urandom_range(0, NUM + 1)), 4'h0, 32'h0);
         run(1, 60);
      end
      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
